// File: rtl/dds_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dds_wr_arbiter
// Purpose  : Round-robin arbiter placing three requesters onto a single DDS
//            register write engine. One transaction is in flight at a time.
//            Grant, address and data are latched at grant time, so requesters
//            may change their inputs once they have been granted.
// Ports    : clk, rst        - clock (rising edge), asynchronous active-high reset
//            req[2:0]        - per-requester request level
//            req_addr[23:0]  - 8-bit address slice per requester
//            req_data[95:0]  - 32-bit data slice per requester
//            done[2:0]       - one-cycle completion pulse to the owning requester
//            err[2:0]        - one-cycle timeout flag, coincident with done
//            rdata[31:0]     - wr_out captured at completion (0 on timeout)
//            wr_start        - one-cycle start pulse to the write engine
//            wr_addr/wr_data - latched address/data for the write engine
//            wr_done, wr_out - write-engine completion pulse and readback
//            busy, owner     - arbiter busy flag and granted requester index
// Config   : define DDS_WR_ARBITER_TIMEOUT_EN to compile in the WAIT watchdog
//            (TIMEOUT_CYCLES WAIT cycles, legal range 1..65535).
// Revision : 1.0 - initial release
// ============================================================================
module dds_wr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic [31:0] rdata,
  output logic        wr_start,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  input  logic [31:0] wr_out,
  output logic        busy,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_owner;
  logic [1:0]  r_last;
  logic [7:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_rdata;
  logic [1:0]  w_gidx;
  logic [7:0]  w_gaddr;
  logic [31:0] w_gdata;
  logic [2:0]  w_owner_oh;
  logic        w_timeout;

  assign w_owner_oh = 3'b001 << r_owner;
  assign owner      = r_owner;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign rdata      = r_rdata;

  // Round-robin search starting at (last+1) mod 3. Only meaningful when |req.
  always_comb begin
    w_gidx = 2'd0;
    case (r_last)
      2'd0:    w_gidx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    w_gidx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: w_gidx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_gaddr = req_addr[7:0];
    w_gdata = req_data[31:0];
    case (w_gidx)
      2'd1: begin
        w_gaddr = req_addr[15:8];
        w_gdata = req_data[63:32];
      end
      2'd2: begin
        w_gaddr = req_addr[23:16];
        w_gdata = req_data[95:64];
      end
      default: ;
    endcase
  end

`ifdef DDS_WR_ARBITER_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wait_cnt;
  logic        r_timed_out;

  // Counter holds the number of WAIT cycles already elapsed; the abort fires
  // on the edge closing the TIMEOUT_CYCLES-th WAIT cycle.
  assign w_timeout = (r_wait_cnt == c_TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= 16'd0;
      r_timed_out <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= 16'd0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      // A real wr_done wins over a coincident timeout.
      if (r_state == S_WAIT) begin
        r_timed_out <= !wr_done && w_timeout;
      end
    end
  end

  assign err = ((r_state == S_RESP) && r_timed_out) ? w_owner_oh : 3'b000;
`else
  assign w_timeout = 1'b0;
  assign err       = 3'b000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    wr_start = 1'b0;
    done     = 3'b000;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (|req) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_start = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        if (wr_done || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        done   = w_owner_oh;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers; last resets to 2 so requester 0 wins the first grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= 2'd0;
      r_last    <= 2'd2;
      r_wr_addr <= 8'd0;
      r_wr_data <= 32'd0;
      r_rdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner   <= w_gidx;
            r_wr_addr <= w_gaddr;
            r_wr_data <= w_gdata;
          end
        end
        S_WAIT: begin
          if (wr_done) begin
            r_rdata <= wr_out;
          end else if (w_timeout) begin
            r_rdata <= 32'd0;
          end
        end
        S_RESP: r_last <= r_owner;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_wr_arbiter
// Purpose  : Directed self-checking bench for dds_wr_arbiter. Expected
//            transactions are queued when requests are driven and popped when
//            the arbiter issues wr_start; completion is checked against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_wr_arbiter;

  localparam int c_TO = 16;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  done;
  logic [2:0]  err;
  logic [31:0] rdata;
  logic        wr_start;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic [31:0] wr_out;
  logic        busy;
  logic [1:0]  owner;

  typedef struct {
    logic [1:0]  owner;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] rout;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          total = 0;
  int          bad   = 0;
  int          starts = 0;
  logic [7:0]  a_addr [3];
  logic [31:0] a_data [3];

  dds_wr_arbiter #(.TIMEOUT_CYCLES(c_TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .wr_start (wr_start),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .wr_out   (wr_out),
    .busy     (busy),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_start === 1'b1) starts <= starts + 1;
  end

  function automatic logic [2:0] oh(input logic [1:0] i);
    logic [2:0] v;
    v = 3'b000;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d);
    a_addr[i] = a;
    a_data[i] = d;
    req_addr[8*i +: 8]  = a;
    req_data[32*i +: 32] = d;
    req[i] = 1'b1;
  endtask

  task automatic push(input int i, input logic [31:0] rout, input logic e);
    exp_t x;
    x.owner = 2'(i);
    x.addr  = a_addr[i];
    x.data  = a_data[i];
    x.rout  = rout;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Waits (bounded) for wr_start, pops the expected transaction and checks it.
  task automatic wait_grant(input int exp_lat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (wr_start !== 1'b1 && n < 20);
    chk("grant_seen", {31'd0, wr_start}, 32'd1);
    if (exp_lat > 0) chk("grant_latency", n, exp_lat);
    chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("grant_owner", {30'd0, owner}, {30'd0, cur.owner});
      chk("grant_addr", {24'd0, wr_addr}, {24'd0, cur.addr});
      chk("grant_data", wr_data, cur.data);
      chk("grant_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  // Called in the RESP cycle: checks done/err/rdata, drops the owner's request
  // and checks the arbiter is back in IDLE with address/data held.
  task automatic check_resp();
    chk("resp_done", {29'd0, done}, {29'd0, oh(cur.owner)});
    chk("resp_err", {29'd0, err}, cur.err ? {29'd0, oh(cur.owner)} : 32'd0);
    chk("resp_rdata", rdata, cur.rout);
    req[cur.owner] = 1'b0;
    step();
    chk("post_done_low", {29'd0, done}, 32'd0);
    chk("post_idle", {31'd0, busy}, 32'd0);
    chk("hold_addr", {24'd0, wr_addr}, {24'd0, cur.addr});
    chk("hold_data", wr_data, cur.data);
  endtask

  // Called in the ISSUE cycle: wr_done is high during the dly-th WAIT cycle.
  task automatic complete(input int dly);
    step();
    chk("start_one_cycle", {31'd0, wr_start}, 32'd0);
    repeat (dly - 1) step();
    wr_done = 1'b1;
    wr_out  = cur.rout;
    step();
    wr_done = 1'b0;
    wr_out  = 32'h0BAD_F00D;
    check_resp();
  endtask

  task automatic round(input logic [7:0] base);
    int s0;
    s0 = starts;
    set_req(0, base + 8'h00, {24'h100000, base});
    set_req(1, base + 8'h01, {24'h200000, base});
    set_req(2, base + 8'h02, {24'h300000, base});
    push(0, {24'hC00000, base}, 1'b0);
    push(1, {24'hC10000, base}, 1'b0);
    push(2, {24'hC20000, base}, 1'b0);
    wait_grant(1); complete(2);
    wait_grant(1); complete(3);
    wait_grant(1); complete(1);
    chk("round_starts", starts - s0, 32'd3);
  endtask

  initial begin
    int   n;
    logic held;
    rst      = 1'b1;
    req      = 3'b000;
    req_addr = '0;
    req_data = '0;
    wr_done  = 1'b0;
    wr_out   = 32'h0BAD_F00D;
    repeat (2) step();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_start", {31'd0, wr_start}, 32'd0);
    chk("rst_done", {29'd0, done}, 32'd0);
    chk("rst_err", {29'd0, err}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    step();

    // Contention: two full rounds, order 0,1,2 each
    round(8'h40);
    round(8'h80);

    // Fairness: 0 re-asserts immediately, 2 held -> 2 is the second grant
    set_req(0, 8'h50, 32'h5000_0000);
    set_req(2, 8'h52, 32'h5200_0002);
    push(0, 32'hF000_0000, 1'b0);
    push(2, 32'hF000_0002, 1'b0);
    push(0, 32'hF000_0010, 1'b0);
    wait_grant(1); complete(2);
    req[0] = 1'b1;
    wait_grant(1); complete(2);
    wait_grant(1); complete(2);

    // Single request with post-grant input changes
    set_req(0, 8'h0E, 32'h1234_5678);
    push(0, 32'hA5A5_0001, 1'b0);
    wait_grant(1);
    req_addr[7:0]  = 8'hFF;
    req_data[31:0] = 32'h0;
    complete(4);

    // Stray wr_done in IDLE and in ISSUE
    wr_done = 1'b1;
    wr_out  = 32'hDEAD_0001;
    step();
    wr_done = 1'b0;
    chk("stray_idle_rdata", rdata, 32'hA5A5_0001);
    chk("stray_idle_done", {29'd0, done}, 32'd0);
    set_req(1, 8'h21, 32'h2100_0021);
    push(1, 32'h7777_0001, 1'b0);
    wait_grant(1);
    wr_done = 1'b1;
    wr_out  = 32'hDEAD_0002;
    step();
    wr_done = 1'b0;
    repeat (5) step();
    chk("stray_issue_busy", {31'd0, busy}, 32'd1);
    chk("stray_issue_done", {29'd0, done}, 32'd0);
    chk("stray_issue_rdata", rdata, 32'hA5A5_0001);
    wr_done = 1'b1;
    wr_out  = cur.rout;
    step();
    wr_done = 1'b0;
    wr_out  = 32'h0BAD_F00D;
    check_resp();

    // Timeout
    set_req(2, 8'h72, 32'h7200_0072);
`ifdef DDS_WR_ARBITER_TIMEOUT_EN
    push(2, 32'h0, 1'b1);
    wait_grant(1);
    n = 0;
    do begin
      step();
      n++;
    end while (done === 3'b000 && n < 40);
    chk("timeout_latency", n, c_TO + 1);
    check_resp();
    // wr_done coincident with the timeout edge completes normally
    set_req(0, 8'h60, 32'h6000_0060);
    push(0, 32'h6666_0060, 1'b0);
    wait_grant(1);
    complete(c_TO);
`else
    push(2, 32'h7272_0072, 1'b0);
    wait_grant(1);
    held = 1'b1;
    repeat (40) begin
      step();
      held = held & busy & (done == 3'b000);
    end
    chk("no_timeout_busy", {31'd0, held}, 32'd1);
    complete(1);
`endif

    // Reset in WAIT abandons the transaction
    set_req(1, 8'h31, 32'h3100_0031);
    push(1, 32'h3131_0031, 1'b0);
    wait_grant(1);
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_wr_start", {31'd0, wr_start}, 32'd0);
    chk("mid_rst_done", {29'd0, done}, 32'd0);
    chk("mid_rst_owner", {30'd0, owner}, 32'd0);
    step();
    chk("mid_rst_done2", {29'd0, done}, 32'd0);
    rst = 1'b0;
    req = 3'b000;
    step();
    chk("post_rst_done", {29'd0, done}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    set_req(2, 8'h92, 32'h9200_0092);
    push(2, 32'h9292_0092, 1'b0);
    wait_grant(1);
    complete(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_wr_arbiter.md
DDS_WR_ARBITER -- requirements
Module: dds_wr_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, number of WAIT cycles without wr_done before abort; legal range 1..65535.
REQ-002 Port: clk  input  1  clock; all logic is on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  3  per-requester request level; bit i is requester i.
REQ-005 Port: req_addr  input  24  requester register addresses; bits [8i+7:8i] belong to requester i.
REQ-006 Port: req_data  input  96  requester write data; bits [32i+31:32i] belong to requester i.
REQ-007 Port: done  output  3  one-cycle completion pulse per requester.
REQ-008 Port: err  output  3  one-cycle timeout flag per requester; it is coincident with done.
REQ-009 Port: rdata  output  32  wr_out value captured for the completed transaction; it holds until the next completion.
REQ-010 Port: wr_start  output  1  one-cycle start pulse to the DDS register write engine.
REQ-011 Port: wr_addr  output  8  latched address for the write engine.
REQ-012 Port: wr_data  output  32  latched data for the write engine.
REQ-013 Port: wr_done  input  1  write-engine completion pulse.
REQ-014 Port: wr_out  input  32  write-engine readback value; it is valid while wr_done is high.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: owner  output  2  index of the granted requester; it is valid while busy is high.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP, with one transaction in flight at a time.
REQ-018 In IDLE with any req bit high, the block SHALL grant round-robin, searching from (last+1) mod 3 upward, where last is the index of the last completed requester.
REQ-019 On the grant edge, the block SHALL latch owner, wr_addr and wr_data from the granted slice and go to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle, with wr_start=1, then go to WAIT.
REQ-021 wr_start SHALL be 0 in all states other than ISSUE.
REQ-022 wr_done SHALL be honoured only in WAIT; on wr_done in WAIT, rdata<=wr_out and the FSM SHALL go to RESP.
REQ-023 RESP SHALL last exactly one cycle, with done[owner]=1; on exit, last<=owner and the FSM SHALL go to IDLE.
REQ-024 Latency: a req rising in IDLE produces wr_start 1 cycle later; done follows wr_done by 1 cycle.
REQ-025 Requester rule: req, req_addr and req_data stay stable until done is sampled high; req then drops on that same edge.
REQ-026 Dropping req or changing addr/data after the grant SHALL NOT affect the in-flight transaction, because the values are latched.
REQ-027 Simultaneous requests SHALL be resolved by the round-robin order alone; no requester waits more than 2 transactions.
REQ-028 A req bit high in RESP SHALL NOT be granted before IDLE is reached.
REQ-029 wr_done pulses arriving in IDLE, ISSUE or RESP SHALL be ignored and SHALL NOT alter rdata.
REQ-030 wr_addr and wr_data SHALL hold their last values when not busy.

Reset
REQ-031 On rst high, the block SHALL immediately set state=IDLE, wr_start=0, done=0, err=0, busy=0, owner=0, rdata=0, wr_addr=0, wr_data=0, last=2 (requester 0 has first priority) and the timeout counter=0.
REQ-032 A reset during ISSUE, WAIT or RESP SHALL abandon the transaction with no done or err pulse.
REQ-033 The first grant after reset release SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-034 The macro DDS_WR_ARBITER_TIMEOUT_EN SHALL select whether the WAIT watchdog is compiled in.
REQ-035 With DDS_WR_ARBITER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-036 With the watchdog compiled in, reaching TIMEOUT_CYCLES without wr_done SHALL send the FSM to RESP with done[owner]=1, err[owner]=1 and rdata=0.
REQ-037 With the watchdog compiled in, wr_done and timeout in the same cycle SHALL resolve as a normal completion, with err=0.
REQ-038 Without DDS_WR_ARBITER_TIMEOUT_EN, the block SHALL have no counter, err SHALL be constant 0, and WAIT SHALL persist until wr_done.

Verification
REQ-039 Single request: req=3'b001, addr 8'h0E, data 32'h1234_5678; wr_done returned 4 cycles after wr_start with wr_out=32'hA5A5_0001 -> one wr_start pulse with wr_addr=8'h0E and wr_data=32'h1234_5678, then done=3'b001 one cycle after wr_done and rdata=32'hA5A5_0001.
REQ-040 Contention: req=3'b111 held, each requester releasing after its own done -> grant order 0,1,2; a second round with req=3'b111 again -> order 0,1,2; exactly 3 wr_start pulses per round.
REQ-041 Fairness: requester 0 re-asserts immediately after each done while requester 2 is held high -> requester 2 is granted no later than the second transaction.
REQ-042 Stray wr_done: pulse wr_done in IDLE and in the ISSUE cycle -> rdata unchanged, no done pulse, and the FSM still waits in WAIT for a real wr_done.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES=16): wr_done never returned -> done[owner] and err[owner] high 17 cycles after wr_start, rdata=0; without the macro -> busy stays 1 indefinitely.
REQ-044 Mid-operation reset: assert rst during WAIT -> busy=0, wr_start=0, no done; after release, req=3'b100 -> requester 2 is granted and completes normally.
